// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: one quotient/product bit per cycle,
// start/ready/done handshake, flushable from the hazard unit.
module mdu_iterative #(
    parameter int WIDTH     = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [2:0]       op;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] opd;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic             neg_main;
    logic             neg_rem;
    logic             dz;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Undo the magnitude-only iteration: restore signs and pick the output half.
    function automatic logic [WIDTH-1:0] sign_fix(
        input logic [2:0]       f,
        input logic [WIDTH-1:0] hi,
        input logic [WIDTH-1:0] lo,
        input logic             nm,
        input logic             nr,
        input logic             z
    );
        logic [2*WIDTH-1:0] prod;
        logic [WIDTH-1:0]   q;
        logic [WIDTH-1:0]   r;
        prod = {hi, lo};
        if (nm)
            prod = ~prod + {{(2*WIDTH-1){1'b0}}, 1'b1};
        q = nm ? negate(lo) : lo;
        if (z)
            q = '1;
        r = nr ? negate(hi) : hi;
        case (f)
            3'b000:                 return prod[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: return prod[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         return q;
            default:                return r;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] special_res(
        input logic [2:0]       f,
        input logic             z,
        input logic [WIDTH-1:0] x
    );
        if (z)
            return f[1] ? x : '1;
        return f[1] ? '0 : x;
    endfunction

    // Operand decode on the accept edge
    logic             accept;
    logic             a_signed, b_signed;
    logic             sa, sb;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic             in_div, in_dz, in_ovf, early;

    assign accept   = (state == S_IDLE) && start && !flush;
    assign a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                      (funct3 == 3'b100) || (funct3 == 3'b110);
    assign b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign sa       = a_signed && ($signed(a) < 0);
    assign sb       = b_signed && ($signed(b) < 0);
    assign abs_a    = sa ? negate(a) : a;
    assign abs_b    = sb ? negate(b) : b;
    assign in_div   = funct3[2];
    assign in_dz    = in_div && (b == '0);
    assign in_ovf   = in_div && !funct3[0] && (a == MIN_NEG) && (&b);
    assign early    = EARLY_OUT && (in_dz || in_ovf);

    // One iteration step: shift-add for multiply, restoring subtract for divide
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;
    logic [WIDTH-1:0] hi_nxt, lo_nxt;

    always_comb begin
        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd} : {(WIDTH+1){1'b0}});
        div_sh   = {acc_hi, acc_lo[WIDTH-1]};
        div_ge   = div_sh >= {1'b0, opd};
        div_diff = div_sh[WIDTH-1:0] - opd;
        if (op[2]) begin
            hi_nxt = div_ge ? div_diff : div_sh[WIDTH-1:0];
            lo_nxt = {acc_lo[WIDTH-2:0], div_ge};
        end else begin
            hi_nxt = mul_sum[WIDTH:1];
            lo_nxt = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start && !flush) state_nxt = early ? S_DONE : S_CALC;
            S_CALC: begin
                if (flush)
                    state_nxt = S_IDLE;
                else if (cnt == CNT_ONE)
                    state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state)
            S_IDLE:  ready = 1'b1;
            S_CALC:  busy  = 1'b1;
            S_DONE:  done  = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op       <= '0;
            cnt      <= '0;
            opd      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            dz       <= 1'b0;
            result   <= '0;
        end else if (accept) begin
            op       <= funct3;
            cnt      <= CNT_LOAD;
            neg_main <= sa ^ sb;
            neg_rem  <= sa;
            dz       <= in_dz;
            acc_hi   <= '0;
            opd      <= in_div ? abs_b : abs_a;
            acc_lo   <= in_div ? abs_a : abs_b;
            if (early)
                result <= special_res(funct3, in_dz, a);
        end else if (state == S_CALC && !flush) begin
            acc_hi <= hi_nxt;
            acc_lo <= lo_nxt;
            cnt    <= cnt - CNT_ONE;
            if (cnt == CNT_ONE)
                result <= sign_fix(op, hi_nxt, lo_nxt, neg_main, neg_rem, dz);
        end
    end

endmodule
